// File: rtl/dadda_pkg.sv
// Shared definitions for the Dadda multiply-accumulate datapath:
// run-state encoding and default widths.
package dadda_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int PROD_W    = 32;
    localparam int ACC_W_DEF = 40;
    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/mac_run_counter.sv
// Product counter for one accumulate run: loads the run length, counts
// accepted products and flags the product that completes the run.
module mac_run_counter
    import dadda_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             inc_i,
    output logic             last_o
);

    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W:0]   cntNext;

    // One extra bit so that a run of the maximum length still compares correctly.
    assign cntNext = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign last_o  = inc_i && (cntNext == {1'b0, len_q});

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            len_q <= len_i;
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cntNext[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/dadda_mac_acc.sv
// Accumulate stage behind the Dadda multiplier: sums a programmed number of
// 32-bit products into a wide accumulator and hands the result downstream.
module dadda_mac_acc
    import dadda_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic [PROD_W-1:0] p,
    input  logic              p_valid,
    output logic              p_ready,
    output logic [ACC_W-1:0]  res,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              ovf
);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             accept;
    logic             load;
    logic             last;
    logic [ACC_W:0]   sum;

    assign accept = (state_q == ACC) && p_valid;
    assign load   = (state_q == IDLE) && start;
    // Top bit of the widened sum is the carry out of the accumulator.
    assign sum    = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, p};

    mac_run_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .len_i  (len),
        .inc_i  (accept),
        .last_o (last)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (len == '0) ? HOLD : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    acc_d = sum[ACC_W-1:0];
                    ovf_d = ovf_q | sum[ACC_W];
                    if (last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign p_ready   = (state_q == ACC);
    assign res_valid = (state_q == HOLD);
    assign res       = acc_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_dadda_mac_acc.sv
// Self-checking bench for dadda_mac_acc: two instances (40-bit and 33-bit
// accumulators) share stimulus and are checked against an arithmetic model.
module tb_dadda_mac_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic [31:0] p = '0;
    logic        p_valid = 1'b0;
    logic        res_ready = 1'b0;

    logic        pReady40, resValid40, ovf40;
    logic [39:0] res40;
    logic        pReady33, resValid33, ovf33;
    logic [32:0] res33;

    logic [42:0] obs40;
    logic [35:0] obs33;

    int checks = 0;
    int errors = 0;

    logic [31:0] prods[$];
    logic [39:0] eRes40;
    logic [32:0] eRes33;
    logic        eOvf40, eOvf33;

    always #5 clk = ~clk;

    dadda_mac_acc #(.ACC_W(40), .CNT_W(8)) u_dut40 (
        .clk(clk), .rst(rst), .start(start), .len(len), .p(p), .p_valid(p_valid),
        .p_ready(pReady40), .res(res40), .res_valid(resValid40),
        .res_ready(res_ready), .ovf(ovf40)
    );

    dadda_mac_acc #(.ACC_W(33), .CNT_W(8)) u_dut33 (
        .clk(clk), .rst(rst), .start(start), .len(len), .p(p), .p_valid(p_valid),
        .p_ready(pReady33), .res(res33), .res_valid(resValid33),
        .res_ready(res_ready), .ovf(ovf33)
    );

    assign obs40 = {resValid40, pReady40, ovf40, res40};
    assign obs33 = {resValid33, pReady33, ovf33, res33};

    // The whole run is one big unsigned sum; it wraps at 2^W and any wrap means
    // some addition carried out.
    function automatic void modelRun();
        logic [127:0] total;
        total = '0;
        foreach (prods[i]) total += {96'b0, prods[i]};
        eRes40 = total[39:0];
        eOvf40 = |total[127:40];
        eRes33 = total[32:0];
        eOvf33 = |total[127:33];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startRun(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic sendProduct(input logic [31:0] val, output bit ok);
        p       = val;
        p_valid = 1'b1;
        ok      = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (pReady40 && pReady33) ok = 1'b1;
            tick();
        end
        p_valid = 1'b0;
        prods.push_back(val);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({obs40, obs33} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h/%h want 0/0", obs40, obs33);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_three_products();
        logic [31:0] vals[3];
        bit ok;
        vals = '{32'd361935522, 32'd1030738330, 32'd4294770690};
        prods.delete();
        startRun(8'd3);
        checks++;
        if ({pReady40, pReady33, resValid40, resValid33} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL three_start_ready got %b want 1100",
                     {pReady40, pReady33, resValid40, resValid33});
        end
        for (int i = 0; i < 3; i++) begin
            sendProduct(vals[i], ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL three_accept%0d got timeout want accept", i);
            end
            if (i < 2) begin
                checks++;
                if ({resValid40, resValid33} !== 2'b00) begin
                    errors++;
                    $display("[TB] FAIL three_early_valid got %b want 00", {resValid40, resValid33});
                end
            end
        end
        modelRun();
        checks++;
        if (obs40 !== {1'b1, 1'b0, 1'b0, 40'd5687444542}) begin
            errors++;
            $display("[TB] FAIL three_res40 got %h want %h", obs40, {1'b1, 1'b0, 1'b0, 40'd5687444542});
        end
        checks++;
        if (obs33 !== {1'b1, 1'b0, eOvf33, eRes33}) begin
            errors++;
            $display("[TB] FAIL three_res33 got %h want %h", obs33, {1'b1, 1'b0, eOvf33, eRes33});
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if ({resValid40, pReady40, resValid33, pReady33} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL three_idle got %b want 0000", {resValid40, pReady40, resValid33, pReady33});
        end
    endtask

    task automatic test_stall();
        logic [31:0] vals[3];
        bit ok;
        vals = '{32'd361935522, 32'd1030738330, 32'd4294770690};
        prods.delete();
        startRun(8'd3);
        for (int i = 0; i < 3; i++) begin
            sendProduct(vals[i], ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL stall_accept%0d got timeout want accept", i);
            end
            if (i < 2) begin
                for (int s = 0; s < 4; s++) begin
                    checks++;
                    if ({pReady40, resValid40, pReady33, resValid33} !== 4'b1010) begin
                        errors++;
                        $display("[TB] FAIL stall_wait got %b want 1010",
                                 {pReady40, resValid40, pReady33, resValid33});
                    end
                    tick();
                end
            end
        end
        checks++;
        if (obs40 !== {1'b1, 1'b0, 1'b0, 40'd5687444542}) begin
            errors++;
            $display("[TB] FAIL stall_res40 got %h want %h", obs40, {1'b1, 1'b0, 1'b0, 40'd5687444542});
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_overflow();
        bit ok;
        prods.delete();
        startRun(8'd3);
        for (int i = 0; i < 3; i++) sendProduct(32'd4294770690, ok);
        modelRun();
        checks++;
        if (obs33 !== {1'b1, 1'b0, 1'b1, 33'd4294377478}) begin
            errors++;
            $display("[TB] FAIL ovf_res33 got %h want %h", obs33, {1'b1, 1'b0, 1'b1, 33'd4294377478});
        end
        checks++;
        if (obs40 !== {1'b1, 1'b0, eOvf40, eRes40}) begin
            errors++;
            $display("[TB] FAIL ovf_res40 got %h want %h", obs40, {1'b1, 1'b0, eOvf40, eRes40});
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        prods.delete();
        startRun(8'd1);
        sendProduct(32'd5, ok);
        checks++;
        if ({obs40, obs33} !== {1'b1, 1'b0, 1'b0, 40'd5, 1'b1, 1'b0, 1'b0, 33'd5}) begin
            errors++;
            $display("[TB] FAIL ovf_clear got %h/%h want res 5 ovf 0", obs40, obs33);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_zero_len();
        p       = 32'd123;
        p_valid = 1'b1;
        startRun(8'd0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({obs40, obs33} !== {1'b1, 1'b0, 1'b0, 40'd0, 1'b1, 1'b0, 1'b0, 33'd0}) begin
                errors++;
                $display("[TB] FAIL zero_len_hold got %h/%h want valid res 0", obs40, obs33);
            end
            if (i == 2) res_ready = 1'b1;
            tick();
        end
        res_ready = 1'b0;
        checks++;
        if ({resValid40, pReady40, resValid33, pReady33} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL zero_len_idle got %b want 0000", {resValid40, pReady40, resValid33, pReady33});
        end
        p_valid = 1'b0;
    endtask

    task automatic test_back_pressure();
        bit ok;
        prods.delete();
        startRun(8'd2);
        sendProduct($urandom, ok);
        sendProduct($urandom, ok);
        modelRun();
        for (int i = 0; i < 6; i++) begin
            start   = 1'b1;
            len     = 8'd5;
            p_valid = 1'b1;
            checks++;
            if ({obs40, obs33} !== {1'b1, 1'b0, eOvf40, eRes40, 1'b1, 1'b0, eOvf33, eRes33}) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d got %h/%h want %h/%h", i, obs40, obs33,
                         {1'b1, 1'b0, eOvf40, eRes40}, {1'b1, 1'b0, eOvf33, eRes33});
            end
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        start     = 1'b0;
        p_valid   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({resValid40, pReady40, resValid33, pReady33} !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL bp_release%0d got %b want 0000", i,
                         {resValid40, pReady40, resValid33, pReady33});
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        prods.delete();
        startRun(8'd3);
        sendProduct(32'hDEAD_BEEF, ok);
        sendProduct(32'h1234_5678, ok);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({obs40, obs33} !== '0) begin
            errors++;
            $display("[TB] FAIL midrst_outputs got %h/%h want 0/0", obs40, obs33);
        end
        prods.delete();
        startRun(8'd1);
        sendProduct(32'd7, ok);
        checks++;
        if ({obs40, obs33} !== {1'b1, 1'b0, 1'b0, 40'd7, 1'b1, 1'b0, 1'b0, 33'd7}) begin
            errors++;
            $display("[TB] FAIL midrst_newrun got %h/%h want res 7", obs40, obs33);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_random_runs();
        bit ok;
        int n;
        for (int r = 0; r < 8; r++) begin
            prods.delete();
            n = $urandom_range(1, 6);
            startRun(8'(n));
            for (int i = 0; i < n; i++) begin
                sendProduct((r % 2 == 0) ? 32'($urandom) : 32'hFFFF_0000 | 32'($urandom_range(0, 65535)), ok);
                checks++;
                if (!ok) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_accept%0d got timeout want accept", r, i);
                end
                repeat ($urandom_range(0, 2)) tick();
            end
            modelRun();
            repeat ($urandom_range(0, 3)) tick();
            checks++;
            if ({obs40, obs33} !== {1'b1, 1'b0, eOvf40, eRes40, 1'b1, 1'b0, eOvf33, eRes33}) begin
                errors++;
                $display("[TB] FAIL rand%0d_res got %h/%h want %h/%h", r, obs40, obs33,
                         {1'b1, 1'b0, eOvf40, eRes40}, {1'b1, 1'b0, eOvf33, eRes33});
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_three_products();
        test_stall();
        test_overflow();
        test_zero_len();
        test_back_pressure();
        test_reset_mid_run();
        test_random_runs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dadda_mac_acc.md
# dadda_mac_acc

Sequential accumulate stage directly downstream of the 16-bit Dadda multiplier. It consumes the multiplier's unsigned 32-bit product over a valid/ready handshake and sums a programmed number of products into a wide accumulator. It then presents the sum on a second valid/ready handshake. Together with the multiplier it forms a multiply-accumulate datapath.

## Interface
- `ACC_W`, default 40: accumulator and result width in bits; legal range 33..64.
- `CNT_W`, default 8: width of the product-count field.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begins a run; sampled only in IDLE.
- `len` in [CNT_W:1]: number of products to accumulate; captured on the cycle `start` is accepted.
- `p` in [32:1]: unsigned product from the multiplier's 32-bit output.
- `p_valid` in 1: `p` is valid this cycle.
- `p_ready` out 1: the block accepts `p` this cycle.
- `res` out [ACC_W:1]: accumulated sum.
- `res_valid` out 1: `res` is valid.
- `res_ready` in 1: downstream accepts `res`.
- `ovf` out 1: sticky flag; set if any addition in the run carried out of bit ACC_W.

## Operation
- There are three states: IDLE, ACC and HOLD.
- **IDLE**
  - `p_ready`=0 and `res_valid`=0.
  - On `start`=1, the block captures `len`, clears the accumulator, the count and `ovf`.
  - Next state is ACC if `len`≠0. If `len`=0, next state is HOLD with `res`=0.
- **ACC**
  - `p_ready`=1.
  - A product is accepted on each cycle with `p_valid`&&`p_ready`: acc ← acc + zero-extended `p`, and count ← count+1.
  - When the accepted product is number `len`, next state is HOLD.
  - Cycles without `p_valid` hold all state; stalls of any length are legal.
- **HOLD**
  - `res_valid`=1 and `res`=acc; `res` is stable while held.
  - On `res_ready`=1, next state is IDLE.
- **Ignored inputs**
  - `start` is ignored in ACC and HOLD; the captured `len` does not change.
  - `p_valid` is ignored outside ACC, and no product is consumed.
- **Arithmetic**
  - The addition is unsigned, modulo 2^ACC_W.
  - Any carry out of the top bit sets `ovf`, which stays set until the next accepted `start` or `rst`.
  - `ovf` is valid alongside `res` in HOLD.
- **Reset**: `rst`=1 in any state, including mid-run, forces IDLE on the next edge. It clears the accumulator, count, captured len and `ovf`. Any partial sum is discarded.
- **Simultaneous events**
  - Final product accepted in ACC: HOLD begins next cycle; `p_ready` is 0 in HOLD.
  - `res_ready` with `start` in the same HOLD cycle: `start` is ignored, and the block goes to IDLE.

## Timing
- **Reset values**: state=IDLE, `p_ready`=0, `res_valid`=0, `res`=0, `ovf`=0.
- **Output style**: all outputs are registered or decoded purely from state (Moore); there is no combinational path from any input to any output.
- **`start` to first product**: `start` in cycle t → `p_ready`=1 in cycle t+1.
- **Last product to result**: the last product accepted in cycle t → `res_valid`=1 and the final `res` in cycle t+1.
- **`len`=0**: `start` in cycle t → `res_valid`=1 in cycle t+1.
- **Throughput**: one product per cycle in ACC. A run of N products occupies N+2 cycles minimum, from `start` through the `res` handshake. The block returns to IDLE one cycle after `res_ready`.

## Structure
- Shared package `dadda_pkg` holds:
  - the state encoding (IDLE=2'd0, ACC=2'd1, HOLD=2'd2);
  - `PROD_W`=32;
  - the default `ACC_W` and `CNT_W`.
- One sub-module is natural: `mac_run_counter`, which loads `len`, increments on each accepted product, and flags the last product.
- The accumulator adder and the FSM stay in the top module. The multiplier is not instantiated inside; it connects externally to `p`.

## Test plan
- **Three-product run**: `len`=3, products 361935522, 1030738330 and 4294770690 (from 7239×49998, 23230×44371 and 65535×65534) sent back-to-back → `res`=5687444542, `ovf`=0, `res_valid` one cycle after the third accept.
- **Stalled input**: same run with `p_valid` low for 4 cycles between products → same `res`; count and acc unchanged during stalls.
- **Overflow**: `ACC_W`=33, `len`=3, `p`=4294770690 three times → `res`=4294377478, `ovf`=1. A following run of `len`=1 with `p`=5 → `res`=5, `ovf`=0.
- **Zero length**: `start` with `len`=0 → `res_valid`=1 next cycle with `res`=0, and `p_ready` never asserts.
- **Back-pressure**: hold `res_ready`=0 for 6 cycles in HOLD → `res` stable, `p_ready`=0, `start` ignored. Release → IDLE next cycle.
- **Reset mid-run**: `rst` pulsed after 2 of 3 products → all outputs at reset values next cycle. A new run with `len`=1 and `p`=7 → `res`=7.
